dmem_port_arbiter: RTL and testbench

Arbitrates the single-ported data memory between the pipeline MEM stage and a host/loader port. The host port is used to preload SAD frame data and read back results. The block sequences every access through a fixed-latency memory, stalls the pipeline while it waits, and bounds host starvation with a loss counter. It sits between the EX/MEM pipeline register outputs and DataMemory, and feeds its stall into the hazard unit.

---
 rtl/dmem_port_arbiter_if.sv | 44 ++++
 rtl/dmem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: pipeline MEM-stage port, host/loader port and DataMemory port.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              pipe_req;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic [DATA_W-1:0] pipe_rdata;
    logic              pipe_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output pipe_rdata, pipe_stall, host_gnt, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output pipe_req, pipe_we, pipe_addr, pipe_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  pipe_rdata, pipe_stall, host_gnt, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port DataMemory arbiter between the MEM stage and the host loader, with bounded host starvation.
// Optional perf counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 2,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   arb_bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_stall_cycles,
    output logic [15:0]          perf_host_grants
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_P = 2'd1,
        BUSY_H = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_lat_cnt;
    logic [3:0]        r_loss_cnt;
    logic              r_we;
    logic [DATA_W-1:0] r_pipe_rdata;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_idle;
    logic              w_done;
    logic              w_grant_host;
    logic              w_issue;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_pipe_cpl;
    logic              w_pipe_rd_done;
    logic              w_host_gnt;
    logic              w_host_rd_done;

    assign w_idle       = (r_state == IDLE);
    assign w_done       = !w_idle && (r_lat_cnt == 3'd1);
    assign w_grant_host = arb_bus.host_req &&
                          (!arb_bus.pipe_req || (r_loss_cnt >= 4'(HOST_MAX_WAIT)));
    // Gating with rst keeps the issue strobe and stall low during reset without waiting for a clock.
    assign w_issue      = rst && w_idle && (arb_bus.pipe_req || arb_bus.host_req);

    assign w_we    = w_grant_host ? arb_bus.host_we    : arb_bus.pipe_we;
    assign w_addr  = w_grant_host ? arb_bus.host_addr  : arb_bus.pipe_addr;
    assign w_wdata = w_grant_host ? arb_bus.host_wdata : arb_bus.pipe_wdata;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_pipe_cpl     = 1'b0;
        w_host_gnt     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_issue) w_state_next = w_grant_host ? BUSY_H : BUSY_P;
            end
            BUSY_P: begin
                w_pipe_cpl = w_done;
                if (w_done) w_state_next = IDLE;
            end
            BUSY_H: begin
                w_host_gnt = w_done;
                if (w_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A flushed pipe access still completes, but its read data is dropped.
    assign w_pipe_rd_done = w_pipe_cpl && !r_we && arb_bus.pipe_req;
    assign w_host_rd_done = w_host_gnt && !r_we;

    assign arb_bus.mem_en     = w_issue;
    assign arb_bus.mem_we     = w_issue && w_we;
    assign arb_bus.mem_addr   = w_addr;
    assign arb_bus.mem_wdata  = w_wdata;
    assign arb_bus.pipe_stall = rst && arb_bus.pipe_req && !w_pipe_cpl;
    assign arb_bus.pipe_rdata = w_pipe_rd_done ? arb_bus.mem_rdata : r_pipe_rdata;
    assign arb_bus.host_gnt   = w_host_gnt;
    assign arb_bus.host_rdata = w_host_rd_done ? arb_bus.mem_rdata : r_host_rdata;
    assign arb_bus.busy       = !w_idle;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_lat_cnt    <= 3'd0;
            r_loss_cnt   <= 4'd0;
            r_we         <= 1'b0;
            r_pipe_rdata <= '0;
            r_host_rdata <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_issue) begin
                r_lat_cnt <= 3'(MEM_LAT);
                r_we      <= w_we;
            end else if (!w_idle) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end

            if (w_issue && w_grant_host)
                r_loss_cnt <= 4'd0;
            else if (w_issue && arb_bus.host_req)
                r_loss_cnt <= (r_loss_cnt == 4'hF) ? r_loss_cnt : r_loss_cnt + 4'd1;
            else if (w_idle && !arb_bus.host_req)
                r_loss_cnt <= 4'd0;

            if (w_pipe_rd_done) r_pipe_rdata <= arb_bus.mem_rdata;
            if (w_host_rd_done) r_host_rdata <= arb_bus.mem_rdata;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cycles <= '0;
            perf_host_grants  <= '0;
        end else begin
            if (arb_bus.pipe_stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (w_host_gnt && (perf_host_grants != '1))
                perf_host_grants <= perf_host_grants + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random traffic against a
// cycle-numbered transaction model and a latency-accurate memory responder.
module tb_dmem_port_arbiter;

    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int MEM_LAT       = 2;
    localparam int HOST_MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [15:0] perf_host_grants;
`endif

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .HOST_MAX_WAIT(HOST_MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arb_bus(bus_if)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_host_grants(perf_host_grants)
`endif
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Word-indexed memories: the responder follows the DUT's strobes, the model follows the rules.
    logic [31:0] resp_mem [16];
    logic [31:0] ref_mem  [16];
    int          sched_cyc  [8];
    logic [31:0] sched_data [8];

    // Reference model: an access owns the memory from its issue cycle through cycle m_done.
    int          cyc;
    int          m_done;
    int          m_loss;
    bit          m_own_h;
    bit          m_we;
    logic [31:0] m_rd;
    logic [31:0] m_prd;
    logic [31:0] m_hrd;
    int          m_stall_cnt;
    int          m_gnt_cnt;

    bit          s_preq, s_pwe, s_hreq, s_hwe;
    logic [31:0] s_paddr, s_pwdata, s_haddr, s_hwdata;
    bit          last_pdone, last_hdone;

    task automatic model_reset();
        m_done      = -1;
        m_loss      = 0;
        m_own_h     = 1'b0;
        m_we        = 1'b0;
        m_rd        = '0;
        m_prd       = '0;
        m_hrd       = '0;
        m_stall_cnt = 0;
        m_gnt_cnt   = 0;
        last_pdone  = 1'b0;
        last_hdone  = 1'b0;
        for (int i = 0; i < 8; i++) sched_cyc[i] = -1;
    endtask

    // Entered at a falling edge: drive, check combinational outputs, advance model, wait next falling edge.
    task automatic step();
        bit          idle, comp, iss, hst, e_stall, e_gnt, we;
        logic [31:0] a, wd, exp_prd, exp_hrd;
        logic [3:0]  idx;
        int          slot;

        bus_if.pipe_req   = s_preq;
        bus_if.pipe_we    = s_pwe;
        bus_if.pipe_addr  = s_paddr;
        bus_if.pipe_wdata = s_pwdata;
        bus_if.host_req   = s_hreq;
        bus_if.host_we    = s_hwe;
        bus_if.host_addr  = s_haddr;
        bus_if.host_wdata = s_hwdata;
        slot = cyc % 8;
        bus_if.mem_rdata = (sched_cyc[slot] == cyc) ? sched_data[slot] : $urandom;
        #1;

        if (bus_if.mem_en) begin
            idx  = bus_if.mem_addr[5:2];
            slot = (cyc + MEM_LAT) % 8;
            sched_cyc[slot]  = cyc + MEM_LAT;
            sched_data[slot] = resp_mem[idx];
            if (bus_if.mem_we) resp_mem[idx] = bus_if.mem_wdata;
        end

        idle    = (cyc > m_done);
        comp    = (cyc == m_done);
        iss     = idle && (s_preq || s_hreq);
        hst     = s_hreq && (!s_preq || (m_loss >= HOST_MAX_WAIT));
        a       = hst ? s_haddr  : s_paddr;
        wd      = hst ? s_hwdata : s_pwdata;
        we      = hst ? s_hwe    : s_pwe;
        e_stall = s_preq && !(comp && !m_own_h);
        e_gnt   = comp && m_own_h;
        exp_prd = (comp && !m_own_h && !m_we && s_preq) ? m_rd : m_prd;
        exp_hrd = (e_gnt && !m_we) ? m_rd : m_hrd;

        check("mem_en", 32'(bus_if.mem_en), 32'(iss));
        check("mem_we", 32'(bus_if.mem_we), 32'(iss && we));
        if (iss) begin
            check("mem_addr", bus_if.mem_addr, a);
            if (we) check("mem_wdata", bus_if.mem_wdata, wd);
        end
        check("pipe_stall", 32'(bus_if.pipe_stall), 32'(e_stall));
        check("host_gnt",   32'(bus_if.host_gnt),   32'(e_gnt));
        check("busy",       32'(bus_if.busy),       32'(!idle));
        check("pipe_rdata", bus_if.pipe_rdata, exp_prd);
        check("host_rdata", bus_if.host_rdata, exp_hrd);

        last_pdone = s_preq && !e_stall;
        last_hdone = e_gnt;
        if (e_stall) m_stall_cnt++;
        if (e_gnt)   m_gnt_cnt++;
        m_prd = exp_prd;
        m_hrd = exp_hrd;

        if (iss && hst)                   m_loss = 0;
        else if (iss && s_hreq)           m_loss = (m_loss < 15) ? m_loss + 1 : 15;
        else if (idle && !s_hreq)         m_loss = 0;

        if (iss) begin
            m_done  = cyc + MEM_LAT;
            m_own_h = hst;
            m_we    = we;
            m_rd    = ref_mem[a[5:2]];
            if (we) ref_mem[a[5:2]] = wd;
        end
        cyc++;
        @(negedge clk);
    endtask

    // mode: 0 = no new requests, 1 = always request, 2 = random
    task automatic gen(input int pmode, input int hmode);
        if (!s_preq || last_pdone) begin
            s_preq   = (pmode == 1) || (pmode == 2 && $urandom_range(0, 1) == 1);
            s_pwe    = 1'($urandom_range(0, 1));
            s_paddr  = {26'd0, 4'($urandom), 2'd0};
            s_pwdata = $urandom;
        end else if (pmode == 2 && $urandom_range(0, 19) == 0) begin
            s_preq = 1'b0;
        end
        if (!s_hreq || last_hdone) begin
            s_hreq   = (hmode == 1) || (hmode == 2 && $urandom_range(0, 3) == 0);
            s_hwe    = 1'($urandom_range(0, 1));
            s_haddr  = {26'd0, 4'($urandom), 2'd0};
            s_hwdata = $urandom;
        end
    endtask

    task automatic run(input int n, input int pmode, input int hmode);
        for (int i = 0; i < n; i++) begin
            gen(pmode, hmode);
            step();
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_en"},     32'(bus_if.mem_en),     32'd0);
        check({tag, "_mem_we"},     32'(bus_if.mem_we),     32'd0);
        check({tag, "_pipe_stall"}, 32'(bus_if.pipe_stall), 32'd0);
        check({tag, "_host_gnt"},   32'(bus_if.host_gnt),   32'd0);
        check({tag, "_busy"},       32'(bus_if.busy),       32'd0);
        check({tag, "_pipe_rdata"}, bus_if.pipe_rdata,      32'd0);
        check({tag, "_host_rdata"}, bus_if.host_rdata,      32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            resp_mem[i] = $urandom;
            ref_mem[i]  = resp_mem[i];
        end
        resp_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;
        cyc = 0;
        model_reset();

        // Reset held with both requests pending.
        s_preq = 1'b1; s_pwe = 1'b0; s_paddr = 32'h10;  s_pwdata = 32'h0;
        s_hreq = 1'b1; s_hwe = 1'b0; s_haddr = 32'h20;  s_hwdata = 32'h0;
        bus_if.pipe_req = 1'b1; bus_if.pipe_we = 1'b0; bus_if.pipe_addr = 32'h10; bus_if.pipe_wdata = '0;
        bus_if.host_req = 1'b1; bus_if.host_we = 1'b0; bus_if.host_addr = 32'h20; bus_if.host_wdata = '0;
        bus_if.mem_rdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b1;

        // Pipe read of 0x10 wins first, then the waiting host read.
        run(8, 0, 0);

        // Host write 0x100 <- 5, pipe read arrives one cycle later.
        s_preq = 1'b0;
        s_hreq = 1'b1; s_hwe = 1'b1; s_haddr = 32'h100; s_hwdata = 32'h5;
        step();
        s_preq = 1'b1; s_pwe = 1'b0; s_paddr = 32'h24;
        run(8, 0, 0);

        // Starvation bound: continuous pipe traffic against a waiting host.
        s_preq = 1'b0; s_hreq = 1'b0;
        run(60, 1, 1);

        run(600, 2, 2);

        // Drain, issue a host read, then reset one cycle into it.
        s_preq = 1'b0; s_hreq = 1'b0;
        run(MEM_LAT + 2, 0, 0);
        s_hreq = 1'b1; s_hwe = 1'b0; s_haddr = 32'h30;
        step();
        bus_if.mem_rdata = $urandom;
        #3;
        rst = 1'b0;
        #1;
        check_quiet("midrst");
        @(negedge clk);
        #1;
        check("midrst_gnt2",  32'(bus_if.host_gnt), 32'd0);
        check("midrst_busy2", 32'(bus_if.busy),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run(MEM_LAT + 3, 0, 0);

        run(100, 2, 2);

`ifdef DMEM_ARB_PERF_EN
        #1;
        check("perf_stall_cycles", perf_stall_cycles, 32'(m_stall_cnt));
        check("perf_host_grants",  32'(perf_host_grants), 32'(m_gnt_cnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
